// File: rtl/traffic_mon_pkg.sv
// rtl/traffic_mon_pkg.sv - shared phase encoding, display constants and BCD helper
package traffic_mon_pkg;

    typedef enum logic [1:0] {
        PH_OFF = 2'd0,
        PH_A   = 2'd1,
        PH_B   = 2'd2,
        PH_BAD = 2'd3
    } phase_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [7:0] DISP_BLANK = 8'h00;

    // True when both nibbles of a display byte are legal BCD digits.
    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_step_check.sv
// rtl/bcd_step_check.sv - combinational BCD validity and one-step decrement check
//
// Ports:
//   prev   : display value sampled on the previous edge
//   cur    : display value on this edge
//   valid  : every nibble of prev and cur is a legal BCD digit
//   is_dec : cur equals prev decremented by one in BCD
//
// A decrement of a non-BCD prev has no meaning, so prev is part of valid and
// the caller suppresses the step check whenever valid is low.
module bcd_step_check
    import traffic_mon_pkg::*;
(
    input  logic [7:0] prev,
    input  logic [7:0] cur,
    output logic       valid,
    output logic       is_dec
);

    logic [3:0] tens_dec;
    logic [3:0] ones_dec;
    logic [7:0] dec;

    always_comb begin
        tens_dec = prev[7:4];
        ones_dec = prev[3:0] - 4'd1;
        // Borrow from the tens digit: x0 -> (x-1)9.
        if (prev[3:0] == 4'd0) begin
            tens_dec = prev[7:4] - 4'd1;
            ones_dec = BCD_MAX;
        end
        dec = {tens_dec, ones_dec};
    end

    assign valid  = bcd_ok(prev) && bcd_ok(cur);
    assign is_dec = (cur == dec);

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive safety/countdown checker for a traffic-light controller
//
// Optional feature macro: TRAFFIC_MON_IRQ_EN (one-cycle irq on first error; irq tied 0 otherwise)
//
// Ports:
//   CLK          : system clock, rising edge
//   nR           : asynchronous active-low reset
//   A_Light      : street A green light
//   B_Light      : street B green light
//   nOut1        : countdown display 1, BCD {tens, ones}; 8'h00 is blank
//   nOut2        : countdown display 2, must mirror nOut1
//   clr          : synchronous clear of the sticky error flags
//   phase        : current phase, 0=OFF 1=A 2=B 3=BAD
//   err_conflict : sticky, both lights were on together
//   err_count    : sticky, illegal countdown step
//   err_mismatch : sticky, displays disagreed
//   err_bcd      : sticky, a display nibble exceeded 9
//   err_long     : sticky, a green phase lasted more than MAX_GREEN cycles
//   last_len     : length of the most recently completed A or B phase
//   phase_cnt    : phase changes since reset, wrapping
//   irq          : error interrupt pulse
module traffic_light_monitor
    import traffic_mon_pkg::*;
#(
    parameter int MAX_GREEN = 200,
    parameter int CNT_W     = 16,
    parameter int PH_CNT_W  = 8
) (
    input  logic                CLK,
    input  logic                nR,
    input  logic                A_Light,
    input  logic                B_Light,
    input  logic [7:0]          nOut1,
    input  logic [7:0]          nOut2,
    input  logic                clr,
    output logic [1:0]          phase,
    output logic                err_conflict,
    output logic                err_count,
    output logic                err_mismatch,
    output logic                err_bcd,
    output logic                err_long,
    output logic [CNT_W-1:0]    last_len,
    output logic [PH_CNT_W-1:0] phase_cnt,
    output logic                irq
);

    // Flag vector order: {long, bcd, mismatch, count, conflict}
    localparam int NERR = 5;

    phase_t             phase_q, phase_nxt;
    logic [7:0]         prev_disp;
    logic [CNT_W-1:0]   len_q;
    logic [NERR-1:0]    err_q, err_set, err_nxt;
    logic               step_valid, step_is_dec;
    logic               changed, in_green, leaving, count_en;

    bcd_step_check u_step (
        .prev   (prev_disp),
        .cur    (nOut1),
        .valid  (step_valid),
        .is_dec (step_is_dec)
    );

    always_ff @(posedge CLK or negedge nR) begin
        if (!nR) begin
            phase_q <= PH_OFF;
        end else begin
            phase_q <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = PH_OFF;
        case ({A_Light, B_Light})
            2'b10:   phase_nxt = PH_A;
            2'b01:   phase_nxt = PH_B;
            2'b11:   phase_nxt = PH_BAD;
            default: phase_nxt = PH_OFF;
        endcase
    end

    always_comb begin
        changed  = (phase_nxt != phase_q);
        in_green = (phase_q == PH_A) || (phase_q == PH_B);
        leaving  = changed && in_green;
        // The step check is skipped on phase entry (display may load freely)
        // and whenever any digit involved is not BCD.
        count_en = !changed && in_green && (nOut1 != prev_disp)
                   && step_valid && bcd_ok(nOut2);

        err_set    = '0;
        err_set[0] = changed && (phase_nxt == PH_BAD);
        err_set[1] = count_en && !((nOut1 == DISP_BLANK) ||
                                   (prev_disp == DISP_BLANK) || step_is_dec);
        err_set[2] = (nOut1 != nOut2);
        err_set[3] = !bcd_ok(nOut1) || !bcd_ok(nOut2);
        err_set[4] = leaving && (len_q > CNT_W'(MAX_GREEN));

        // A set on the same edge as clr wins.
        err_nxt = (err_q & {NERR{~clr}}) | err_set;
    end

    always_ff @(posedge CLK or negedge nR) begin
        if (!nR) begin
            prev_disp <= DISP_BLANK;
            len_q     <= '0;
            last_len  <= '0;
            phase_cnt <= '0;
            err_q     <= '0;
        end else begin
            prev_disp <= nOut1;
            err_q     <= err_nxt;
            if (changed) begin
                phase_cnt <= phase_cnt + PH_CNT_W'(1);
                len_q     <= ((phase_nxt == PH_A) || (phase_nxt == PH_B))
                             ? CNT_W'(1) : '0;
            end else if (in_green) begin
                if (len_q != '1) begin
                    len_q <= len_q + CNT_W'(1);
                end
            end else begin
                len_q <= '0;
            end
            if (leaving) begin
                last_len <= len_q;
            end
        end
    end

`ifdef TRAFFIC_MON_IRQ_EN
    logic irq_q;

    // Pulse only on the transition from no flags to some flag.
    always_ff @(posedge CLK or negedge nR) begin
        if (!nR) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (err_q == '0) && (err_nxt != '0);
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign phase        = phase_q;
    assign err_conflict = err_q[0];
    assign err_count    = err_q[1];
    assign err_mismatch = err_q[2];
    assign err_bcd      = err_q[3];
    assign err_long     = err_q[4];

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - scoreboard bench with a behavioural reference model
module tb_traffic_light_monitor;

    localparam int MAX_GREEN = 200;
    localparam int CNT_W     = 16;
    localparam int PH_CNT_W  = 8;

    logic                CLK = 1'b0;
    logic                nR;
    logic                A_Light, B_Light, clr;
    logic [7:0]          nOut1, nOut2;
    logic [1:0]          phase;
    logic                err_conflict, err_count, err_mismatch, err_bcd, err_long;
    logic [CNT_W-1:0]    last_len;
    logic [PH_CNT_W-1:0] phase_cnt;
    logic                irq;

    traffic_light_monitor #(
        .MAX_GREEN (MAX_GREEN),
        .CNT_W     (CNT_W),
        .PH_CNT_W  (PH_CNT_W)
    ) dut (
        .CLK          (CLK),
        .nR           (nR),
        .A_Light      (A_Light),
        .B_Light      (B_Light),
        .nOut1        (nOut1),
        .nOut2        (nOut2),
        .clr          (clr),
        .phase        (phase),
        .err_conflict (err_conflict),
        .err_count    (err_count),
        .err_mismatch (err_mismatch),
        .err_bcd      (err_bcd),
        .err_long     (err_long),
        .last_len     (last_len),
        .phase_cnt    (phase_cnt),
        .irq          (irq)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ph;
        int conflict, count, mismatch, bcd, long_f;
        int last_len;
        int pcnt;
        int irq;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ph = 0, m_len = 0, m_prev = 0, m_last = 0, m_pcnt = 0;
    int m_conf = 0, m_cnt = 0, m_mm = 0, m_bcd = 0, m_long = 0, m_irq = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit bad_bcd(input int v);
        return ((v >> 4) & 15) > 9 || (v & 15) > 9;
    endfunction

    function automatic int bcd_minus_one(input int v);
        int n;
        n = ((v >> 4) & 15) * 10 + (v & 15) - 1;
        return ((n / 10) << 4) | (n % 10);
    endfunction

    function automatic int to_bcd(input int n);
        return ((n / 10) << 4) | (n % 10);
    endfunction

    // Apply one clock's worth of inputs to the model and queue the result.
    task automatic step(input bit a, input bit b, input int n1, input int n2, input bit c);
        int  np, any_old, any_new;
        bit  chg, green, skip;
        exp_t e;
        @(negedge CLK);
        A_Light = a; B_Light = b; nOut1 = 8'(n1); nOut2 = 8'(n2); clr = c;

        np    = (a && !b) ? 1 : (!a && b) ? 2 : (a && b) ? 3 : 0;
        chg   = (np != m_ph);
        green = (m_ph == 1 || m_ph == 2);
        any_old = m_conf | m_cnt | m_mm | m_bcd | m_long;
        if (c) begin
            m_conf = 0; m_cnt = 0; m_mm = 0; m_bcd = 0; m_long = 0;
        end
        if (chg && np == 3) m_conf = 1;
        if (n1 != n2) m_mm = 1;
        if (bad_bcd(n1) || bad_bcd(n2)) m_bcd = 1;
        skip = bad_bcd(n1) || bad_bcd(n2) || bad_bcd(m_prev);
        if (!chg && green && n1 != m_prev && !skip &&
            !(n1 == 0 || m_prev == 0 || n1 == bcd_minus_one(m_prev)))
            m_cnt = 1;
        if (chg && green) begin
            m_last = m_len;
            if (m_len > MAX_GREEN) m_long = 1;
        end
        if (chg) begin
            m_pcnt = (m_pcnt + 1) % 256;
            m_len  = (np == 1 || np == 2) ? 1 : 0;
        end else if (green) begin
            m_len = (m_len < 65535) ? m_len + 1 : 65535;
        end else begin
            m_len = 0;
        end
        m_ph   = np;
        m_prev = n1;
        any_new = m_conf | m_cnt | m_mm | m_bcd | m_long;
`ifdef TRAFFIC_MON_IRQ_EN
        m_irq = (!any_old && any_new) ? 1 : 0;
`else
        m_irq = 0;
`endif
        e.ph = m_ph; e.conflict = m_conf; e.count = m_cnt; e.mismatch = m_mm;
        e.bcd = m_bcd; e.long_f = m_long; e.last_len = m_last; e.pcnt = m_pcnt;
        e.irq = m_irq;
        q.push_back(e);
    endtask

    // Monitor: compares every post-edge output set against the queued model result.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("phase",        int'(phase),        e.ph);
            chk("err_conflict", int'(err_conflict), e.conflict);
            chk("err_count",    int'(err_count),    e.count);
            chk("err_mismatch", int'(err_mismatch), e.mismatch);
            chk("err_bcd",      int'(err_bcd),      e.bcd);
            chk("err_long",     int'(err_long),     e.long_f);
            chk("last_len",     int'(last_len),     e.last_len);
            chk("phase_cnt",    int'(phase_cnt),    e.pcnt);
            chk("irq",          int'(irq),          e.irq);
        end
    end

    initial begin
        int a, b, sel, n1, n2, lights;
        nR = 1'b0; A_Light = 0; B_Light = 0; nOut1 = 0; nOut2 = 0; clr = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_phase",     int'(phase), 0);
        chk("reset_errs",      int'({err_conflict, err_count, err_mismatch, err_bcd, err_long}), 0);
        chk("reset_last_len",  int'(last_len), 0);
        chk("reset_phase_cnt", int'(phase_cnt), 0);
        chk("reset_irq",       int'(irq), 0);
        @(negedge CLK);
        nR = 1'b1;

        repeat (3) step(0, 0, 8'h00, 8'h00, 0);

        // Legal A phase: 30 cycles counting 12 down to 00
        for (int i = 0; i < 30; i++) begin
            n1 = (12 - i / 2 > 0) ? to_bcd(12 - i / 2) : 0;
            step(1, 0, n1, n1, 0);
        end
        step(0, 0, 8'h00, 8'h00, 0);

        // Illegal step in B, then clear
        step(0, 1, 8'h20, 8'h20, 0);
        step(0, 1, 8'h18, 8'h18, 0);
        step(0, 1, 8'h18, 8'h18, 1);
        step(0, 1, 8'h17, 8'h17, 0);

        // Conflict for one cycle
        step(1, 1, 8'h00, 8'h00, 0);
        step(0, 0, 8'h00, 8'h00, 0);
        step(0, 0, 8'h00, 8'h00, 1);

        // Display faults: mismatch under clr, then invalid BCD inside A
        step(0, 0, 8'h35, 8'h34, 1);
        step(0, 0, 8'h00, 8'h00, 1);
        step(1, 0, 8'h40, 8'h40, 0);
        step(1, 0, 8'h3A, 8'h3A, 0);
        step(1, 0, 8'h39, 8'h39, 0);
        step(0, 0, 8'h00, 8'h00, 1);

        // Long green 201 cycles, then exactly 200
        for (int i = 0; i < 201; i++) step(1, 0, 8'h00, 8'h00, 0);
        step(0, 0, 8'h00, 8'h00, 0);
        step(0, 0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 200; i++) step(1, 0, 8'h00, 8'h00, 0);
        step(0, 0, 8'h00, 8'h00, 0);

        // Randomized traffic
        lights = 0; n1 = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                sel = $urandom_range(0, 9);
                lights = (sel < 4) ? 1 : (sel < 8) ? 2 : (sel < 9) ? 0 : 3;
            end
            a = (lights == 1 || lights == 3) ? 1 : 0;
            b = (lights == 2 || lights == 3) ? 1 : 0;
            sel = $urandom_range(0, 15);
            if (sel < 10)
                n1 = (n1 != 0 && !bad_bcd(n1)) ? bcd_minus_one(n1) : 8'h30;
            else if (sel < 12)
                n1 = 0;
            else if (sel < 14)
                n1 = to_bcd($urandom_range(0, 99));
            else if (sel < 15)
                n1 = $urandom_range(0, 255);
            n2 = ($urandom_range(0, 31) == 0) ? $urandom_range(0, 255) : n1;
            step(a[0], b[0], n1, n2, ($urandom_range(0, 15) == 0));
        end

        @(negedge CLK);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
        if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
